// File: rtl/bus_arbiter.sv
// Two-master arbiter onto one slave bus; optional round-robin via BUS_ARB_ROUND_ROBIN_EN (default: m0 fixed priority).
// Latency: gnt at T, slave enable at T+1, done at T+3. Losing requester simply waits, with no gnt, until selected.
`ifndef Ram_base
`define Ram_base 64'h0000_0000_8000_0000
`endif

module bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic              m0_re,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic              m1_re,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_write_data,
    output logic              s_write_enable,
    output logic              s_read_enable,
    input  logic [DATA_W-1:0] s_read_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(`Ram_base);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              sel_vld;
    logic              sel_m1;
    logic              grant_now;
    logic              cap_m1;
    logic              cap_wr;
    logic              cap_rd;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] hold_data;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_m1;

    // On a tie the master that was not granted most recently wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_m1 <= 1'b1;
        end else if (grant_now) begin
            last_m1 <= sel_m1;
        end
    end

    assign sel_m1 = m1_req & (~m0_req | ~last_m1);
`else
    assign sel_m1 = m1_req & ~m0_req;
`endif

    assign sel_vld   = m0_req | m1_req;
    assign grant_now = reset & (state == ST_IDLE) & sel_vld;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (sel_vld) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cap_m1    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_rd    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            hold_data <= '0;
        end else begin
            state <= next_state;
            if (grant_now) begin
                // we+re together is a write; neither is a no-op transfer.
                cap_m1    <= sel_m1;
                cap_addr  <= sel_m1 ? m1_addr  : m0_addr;
                cap_wdata <= sel_m1 ? m1_wdata : m0_wdata;
                cap_wr    <= sel_m1 ? m1_we    : m0_we;
                cap_rd    <= sel_m1 ? (m1_re & ~m1_we) : (m0_re & ~m0_we);
            end
            if (state == ST_WAIT && cap_rd) begin
                hold_data <= s_read_data;
            end
        end
    end

    always_comb begin
        m0_gnt         = grant_now & ~sel_m1;
        m1_gnt         = grant_now & sel_m1;
        busy           = (state != ST_IDLE);
        s_address      = RAM_BASE;
        s_write_data   = '0;
        s_write_enable = 1'b0;
        s_read_enable  = 1'b0;
        m0_done        = 1'b0;
        m1_done        = 1'b0;
        m0_rdata       = '0;
        m1_rdata       = '0;
        if (state == ST_ISSUE) begin
            s_address      = cap_addr;
            s_write_data   = cap_wdata;
            s_write_enable = cap_wr;
            s_read_enable  = cap_rd;
        end
        if (state == ST_DONE) begin
            m0_done = ~cap_m1;
            m1_done = cap_m1;
            if (cap_rd) begin
                if (cap_m1) m1_rdata = hold_data;
                else        m0_rdata = hold_data;
            end
        end
    end

endmodule
